alu_share_ctrl: RTL

Two-requester scheduler for the lab's shared N-bit ALU (add / OR-reduce / AND-reduce / concatenate). It arbitrates round-robin between two valid/ready requesters and drives one combinational ALU instance. Each result is captured in a one-deep output register and held until the consumer accepts it. It sits between the operand sources (switch/keypad front-ends, test sequencers) and the display or result consumer.

---
 rtl/alu_pkg.sv | 15 +
 rtl/alu_core.sv | 33 +++
 rtl/alu_share_ctrl.sv | 105 ++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the shared-ALU scheduler.
// Holds the ALU function codes and the output-register state encoding.
package alu_pkg;

  localparam logic [1:0] FN_ADD = 2'd0;
  localparam logic [1:0] FN_OR  = 2'd1;
  localparam logic [1:0] FN_AND = 2'd2;
  localparam logic [1:0] FN_CAT = 2'd3;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Purely combinational N-bit ALU producing a 2N-bit result.
// Ports:
//   i_a, i_b  : N-bit operands
//   i_fn      : function code (add / OR-reduce / AND-reduce / concatenate)
//   o_result  : 2N-bit result
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic [N-1:0]   i_a,
  input  logic [N-1:0]   i_b,
  input  logic [1:0]     i_fn,
  output logic [2*N-1:0] o_result
);

  logic [N:0] w_sum;

  // Carry lands in bit N of the zero-extended result.
  assign w_sum = {1'b0, i_a} + {1'b0, i_b};

  always_comb begin
    o_result = '0;
    unique case (i_fn)
      FN_ADD:  o_result = {{(N-1){1'b0}}, w_sum};
      FN_OR:   o_result = {{(2*N-1){1'b0}}, |{i_a, i_b}};
      FN_AND:  o_result = {{(2*N-1){1'b0}}, &{i_a, i_b}};
      FN_CAT:  o_result = {i_a, i_b};
      default: o_result = '0;
    endcase
  end

endmodule

// File: rtl/alu_share_ctrl.sv
// Round-robin scheduler for two valid/ready requesters sharing one ALU.
// The accepted operation's result is held in a one-deep output register
// until the consumer takes it; accept and consume may happen on the same edge.
// Ports:
//   i_clk, i_rst_n                 : clock, asynchronous active-low reset
//   i_reqX_valid / o_reqX_ready    : requester X handshake (X = 0, 1)
//   i_reqX_a, i_reqX_b, i_reqX_fn  : requester X operands and function code
//   o_out_valid / i_out_ready      : result handshake
//   o_out_data                     : 2N-bit ALU result
//   o_out_id                       : requester that issued the held result
module alu_share_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic           i_clk,
  input  logic           i_rst_n,
  input  logic           i_req0_valid,
  output logic           o_req0_ready,
  input  logic [N-1:0]   i_req0_a,
  input  logic [N-1:0]   i_req0_b,
  input  logic [1:0]     i_req0_fn,
  input  logic           i_req1_valid,
  output logic           o_req1_ready,
  input  logic [N-1:0]   i_req1_a,
  input  logic [N-1:0]   i_req1_b,
  input  logic [1:0]     i_req1_fn,
  output logic           o_out_valid,
  input  logic           i_out_ready,
  output logic [2*N-1:0] o_out_data,
  output logic           o_out_id
);

  state_t         r_state;
  state_t         w_state_next;
  logic           r_last_grant;
  logic [2*N-1:0] r_data;
  logic           r_id;

  logic           w_can_accept;
  logic           w_grant0;
  logic           w_grant1;
  logic           w_xfer;
  logic           w_sel;
  logic [N-1:0]   w_alu_a;
  logic [N-1:0]   w_alu_b;
  logic [1:0]     w_alu_fn;
  logic [2*N-1:0] w_alu_result;

  // The slot is free when empty, or when the held result leaves this edge.
  assign w_can_accept = (r_state == ST_EMPTY) | i_out_ready;

  // On contention the requester that did not win last time goes first.
  assign w_grant0 = i_req0_valid & (~i_req1_valid | r_last_grant);
  assign w_grant1 = i_req1_valid & (~i_req0_valid | ~r_last_grant);

  assign o_req0_ready = w_grant0 & w_can_accept;
  assign o_req1_ready = w_grant1 & w_can_accept;

  assign w_xfer = (i_req0_valid & o_req0_ready) | (i_req1_valid & o_req1_ready);
  assign w_sel  = w_grant1;

  assign w_alu_a  = w_sel ? i_req1_a  : i_req0_a;
  assign w_alu_b  = w_sel ? i_req1_b  : i_req0_b;
  assign w_alu_fn = w_sel ? i_req1_fn : i_req0_fn;

  alu_core #(
    .N (N)
  ) u_alu_core (
    .i_a      (w_alu_a),
    .i_b      (w_alu_b),
    .i_fn     (w_alu_fn),
    .o_result (w_alu_result)
  );

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      ST_EMPTY: if (w_xfer) w_state_next = ST_FULL;
      ST_FULL:  if (i_out_ready && !w_xfer) w_state_next = ST_EMPTY;
      default:  w_state_next = ST_EMPTY;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_EMPTY;
      r_last_grant <= 1'b1;
      r_data       <= '0;
      r_id         <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (w_xfer) begin
        r_data       <= w_alu_result;
        r_id         <= w_sel;
        r_last_grant <= w_sel;
      end
    end
  end

  assign o_out_valid = (r_state == ST_FULL);
  assign o_out_data  = r_data;
  assign o_out_id    = r_id;

endmodule
